// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit, dispenser handshake, nickel change and refund sequencing
module vend_sequencer #(
  parameter int PRICE        = 3,
  parameter int MAX_CREDIT   = 6,
  parameter int CREDIT_W     = 3,
  parameter int DISP_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                select,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                chg_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);
  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] P  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MX = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [TW-1:0]       TL = TW'(DISP_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, credit_acc;
  logic [CREDIT_W:0] sum;
  logic [1:0] add;
  logic [TW-1:0] tmr, tmr_n;
  logic ph, ph_n, disp_req_n, chg_n, rej_n, fault_n, accept;
  assign add = {1'b0, coin5} + {coin10, 1'b0};
  assign sum = {1'b0, credit} + {{(CREDIT_W - 1){1'b0}}, add};
  assign accept = state == IDLE && !fault && sum <= MX;
  assign credit_acc = accept ? sum[CREDIT_W-1:0] : credit;
  assign busy = state != IDLE;
  // next-state and registered-output values
  always_comb begin
    state_n = state;
    credit_n = credit;
    tmr_n = tmr;
    ph_n = ph;
    disp_req_n = disp_req;
    chg_n = 1'b0;
    rej_n = add != 2'd0 && !accept;
    fault_n = fault;
    case (state)
      IDLE: begin
        credit_n = credit_acc;
        ph_n = 1'b0;
        if (cancel && credit != '0) state_n = CHANGE;
        else if (select && !fault && credit >= P) begin
          state_n = VEND;
          credit_n = credit_acc - P;
          disp_req_n = 1'b1;
          tmr_n = '0;
        end
      end
      VEND: begin
        if (disp_ack) begin
          disp_req_n = 1'b0;
          state_n = credit != '0 ? CHANGE : IDLE;
        end else if (tmr == TL) begin
          credit_n = credit + P;
          fault_n = 1'b1;
          disp_req_n = 1'b0;
          state_n = CHANGE;
        end else tmr_n = tmr + 1'b1;
      end
      CHANGE: begin
        if (ph) ph_n = 1'b0;
        else if (credit == '0) state_n = IDLE;
        else begin
          chg_n = 1'b1;
          credit_n = credit - 1'b1;
          ph_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      credit <= '0;
      tmr <= '0;
      ph <= 1'b0;
      disp_req <= 1'b0;
      chg_pulse <= 1'b0;
      coin_reject <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      tmr <= tmr_n;
      ph <= ph_n;
      disp_req <= disp_req_n;
      chg_pulse <= chg_n;
      coin_reject <= rej_n;
      fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed checks of vend_sequencer against hand-computed values
module tb_vend_sequencer;
  logic clk = 1'b0, reset = 1'b1, coin5 = 1'b0, coin10 = 1'b0, select = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
  logic disp_req, chg_pulse, coin_reject, busy, fault;
  logic [2:0] credit;
  int n_cmp = 0, n_bad = 0, hi;
  vend_sequencer dut (
    .clk(clk), .reset(reset), .coin5(coin5), .coin10(coin10), .select(select), .cancel(cancel),
    .disp_ack(disp_ack), .disp_req(disp_req), .chg_pulse(chg_pulse), .coin_reject(coin_reject),
    .credit(credit), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic c5 = 0, input logic c10 = 0, input logic sel = 0, input logic can = 0);
    coin5 = c5;
    coin10 = c10;
    select = sel;
    cancel = can;
    @(posedge clk);
    #1;
    coin5 = 0;
    coin10 = 0;
    select = 0;
    cancel = 0;
  endtask
  task automatic drain(input int n);
    for (int i = 1; i <= 2 * n; i++) begin
      tick();
      chk("chg_pulse", chg_pulse, i % 2);
      chk("chg_credit", credit, n - (i + 1) / 2);
      chk("chg_busy", busy, 1);
      chk("chg_disp_req", disp_req, 0);
    end
    tick();
    chk("chg_done_busy", busy, 0);
    chk("chg_done_pulse", chg_pulse, 0);
  endtask
  initial begin
    repeat (2) tick();
    reset = 0;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp_req", disp_req, 0);
    chk("rst_fault", fault, 0);
    chk("rst_chg", chg_pulse, 0);
    chk("rst_rej", coin_reject, 0);
    tick(0, 1);
    chk("t1_credit2", credit, 2);
    tick(1, 0);
    chk("t1_credit3", credit, 3);
    tick(0, 0, 1);
    chk("t1_req", disp_req, 1);
    chk("t1_credit0", credit, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_req_hold", disp_req, 1);
    disp_ack = 1;
    tick();
    disp_ack = 0;
    chk("t1_req_drop", disp_req, 0);
    chk("t1_idle", busy, 0);
    chk("t1_no_chg", chg_pulse, 0);
    repeat (3) tick(0, 1);
    chk("t2_credit6", credit, 6);
    tick(0, 0, 1);
    chk("t2_credit3", credit, 3);
    chk("t2_req", disp_req, 1);
    disp_ack = 1;
    tick();
    disp_ack = 0;
    chk("t2_req_drop", disp_req, 0);
    chk("t2_busy", busy, 1);
    drain(3);
    tick(0, 1);
    tick(0, 1);
    tick(1, 0);
    chk("t3_credit5", credit, 5);
    tick(0, 1);
    chk("t3_reject", coin_reject, 1);
    chk("t3_credit_kept", credit, 5);
    tick();
    chk("t3_reject_1cyc", coin_reject, 0);
    tick(0, 0, 0, 1);
    chk("t3_cancel_busy", busy, 1);
    drain(5);
    tick(0, 1);
    tick(0, 0, 1);
    chk("t4_low_req", disp_req, 0);
    chk("t4_low_busy", busy, 0);
    chk("t4_low_credit", credit, 2);
    tick(0, 1);
    tick(0, 0, 1, 1);
    chk("t4_both_req", disp_req, 0);
    chk("t4_both_credit", credit, 4);
    drain(4);
    repeat (3) tick(0, 1);
    tick(0, 0, 1);
    chk("t5_req", disp_req, 1);
    hi = 1;
    tick(1, 0);
    chk("t5_vend_reject", coin_reject, 1);
    chk("t5_vend_credit", credit, 3);
    if (disp_req) hi++;
    for (int i = 0; i < 400 && disp_req; i++) begin
      tick();
      if (disp_req) hi++;
    end
    chk("t5_req_cycles", hi, 255);
    chk("t5_fault", fault, 1);
    chk("t5_req_off", disp_req, 0);
    chk("t5_refund", credit, 6);
    drain(6);
    tick(0, 1);
    chk("t5_fault_reject", coin_reject, 1);
    chk("t5_fault_credit", credit, 0);
    chk("t5_fault_sticky", fault, 1);
    reset = 1;
    tick();
    reset = 0;
    tick(0, 1);
    tick(1, 0);
    tick(0, 0, 1);
    chk("t6_in_vend", disp_req, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t6v_req", disp_req, 0);
    chk("t6v_busy", busy, 0);
    chk("t6v_credit", credit, 0);
    chk("t6v_fault", fault, 0);
    tick(0, 1);
    tick(0, 1);
    tick(0, 0, 0, 1);
    tick();
    chk("t6_in_change", chg_pulse, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t6c_chg", chg_pulse, 0);
    chk("t6c_busy", busy, 0);
    chk("t6c_credit", credit, 0);
    chk("t6c_rej", coin_reject, 0);
    disp_ack = 1;
    tick();
    disp_ack = 0;
    chk("ack_idle_busy", busy, 0);
    chk("ack_idle_req", disp_req, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
